// File: rtl/game_flow_controller_pkg.sv
// Shared state codes and key indices for the game flow controller and its consumers.
package game_flow_controller_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_START        = 3'd0;
    localparam state_t ST_PLAYING      = 3'd1;
    localparam state_t ST_INSTRUCTIONS = 3'd2;
    localparam state_t ST_GAME_OVER    = 3'd3;
    localparam state_t ST_PAUSED       = 3'd4;
    localparam state_t ST_RESPAWN      = 3'd5;

    localparam int NUM_KEYS   = 4;
    localparam int KEY_LEFT   = 0;
    localparam int KEY_RIGHT  = 1;
    localparam int KEY_SELECT = 2;
    localparam int KEY_BACK   = 3;

endpackage

// File: rtl/game_flow_controller_key_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for one active-low key.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          press_reg;
    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            press_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            // Any cycle of agreement restarts the stability window.
            if (sync2_reg == level_reg) begin
                count_reg <= '0;
            end else if (count_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
                count_reg <= '0;
                level_reg <= sync2_reg;
                press_reg <= ~sync2_reg;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign press = press_reg;

endmodule

// File: rtl/game_flow_controller.sv
// Game flow FSM: debounced menu navigation, play/pause, life loss with respawn and game-over lockout.
module game_flow_controller
    import game_flow_controller_pkg::*;
#(
    parameter int N_ITEMS         = 3,
    parameter int LIVES           = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RESPAWN_CYCLES  = 25000000,
    parameter int GO_LOCK_CYCLES  = 50000000,
    localparam int SW = ($clog2(N_ITEMS) > 1) ? $clog2(N_ITEMS) : 1,
    localparam int LW = $clog2(LIVES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_left,
    input  logic          key_right,
    input  logic          key_select,
    input  logic          key_back,
    input  logic          collision,
    output logic [2:0]    state,
    output logic [SW-1:0] menu_sel,
    output logic [LW-1:0] lives,
    output logic          game_start,
    output logic          life_lost,
    output logic          item_pulse
);

    localparam int RW = $clog2(RESPAWN_CYCLES + 1);
    localparam int GW = $clog2(GO_LOCK_CYCLES + 1);

    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] unused_level;

    assign key_raw[KEY_LEFT]   = key_left;
    assign key_raw[KEY_RIGHT]  = key_right;
    assign key_raw[KEY_SELECT] = key_select;
    assign key_raw[KEY_BACK]   = key_back;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key_debounce (
                .clk   (clk),
                .rst   (rst),
                .key_n (key_raw[gi]),
                .level (unused_level[gi]),
                .press (key_press[gi])
            );
        end
    endgenerate

    logic press_left, press_right, press_select, press_back;
    assign press_left   = key_press[KEY_LEFT];
    assign press_right  = key_press[KEY_RIGHT];
    assign press_select = key_press[KEY_SELECT];
    assign press_back   = key_press[KEY_BACK];

    state_t        state_reg, state_next;
    logic [SW-1:0] menu_reg, menu_next;
    logic [LW-1:0] lives_reg, lives_next;
    logic [RW-1:0] respawn_reg, respawn_next;
    logic [GW-1:0] lock_reg, lock_next;
    logic          game_start_reg, game_start_next;
    logic          life_lost_reg, life_lost_next;
    logic          item_pulse_reg, item_pulse_next;
    logic          collision_prev_reg;
    logic          collision_event;

    assign collision_event = collision & ~collision_prev_reg;

    always_comb begin
        state_next      = state_reg;
        menu_next       = menu_reg;
        lives_next      = lives_reg;
        respawn_next    = '0;
        lock_next       = '0;
        game_start_next = 1'b0;
        life_lost_next  = 1'b0;
        item_pulse_next = 1'b0;
        case (state_reg)
            ST_START: begin
                // Select acts on the current highlight; a simultaneous move is dropped.
                if (press_select) begin
                    if (menu_reg == '0) begin
                        state_next      = ST_PLAYING;
                        lives_next      = LW'(LIVES);
                        game_start_next = 1'b1;
                    end else if (menu_reg == SW'(1)) begin
                        state_next = ST_INSTRUCTIONS;
                    end else begin
                        item_pulse_next = 1'b1;
                    end
                end else if (press_right && !press_left) begin
                    menu_next = (menu_reg == SW'(N_ITEMS - 1)) ? '0 : menu_reg + 1'b1;
                end else if (press_left && !press_right) begin
                    menu_next = (menu_reg == '0) ? SW'(N_ITEMS - 1) : menu_reg - 1'b1;
                end
            end
            ST_INSTRUCTIONS: begin
                if (press_back) state_next = ST_START;
            end
            ST_PLAYING: begin
                if (collision_event) begin
                    life_lost_next = 1'b1;
                    if (lives_reg != '0) lives_next = lives_reg - 1'b1;
                    state_next = (lives_reg <= LW'(1)) ? ST_GAME_OVER : ST_RESPAWN;
                end else if (press_back) begin
                    state_next = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (press_back || press_select) state_next = ST_PLAYING;
            end
            ST_RESPAWN: begin
                if (respawn_reg == RW'(RESPAWN_CYCLES - 1)) begin
                    state_next = ST_PLAYING;
                end else begin
                    respawn_next = respawn_reg + 1'b1;
                end
            end
            ST_GAME_OVER: begin
                // Counter saturates at the lockout length; keys count only once it is reached.
                if (lock_reg != GW'(GO_LOCK_CYCLES)) begin
                    lock_next = lock_reg + 1'b1;
                end else if (press_select || press_back) begin
                    state_next = ST_START;
                    menu_next  = '0;
                end else begin
                    lock_next = lock_reg;
                end
            end
            default: begin
                state_next = ST_START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg          <= ST_START;
            menu_reg           <= '0;
            lives_reg          <= LW'(LIVES);
            respawn_reg        <= '0;
            lock_reg           <= '0;
            game_start_reg     <= 1'b0;
            life_lost_reg      <= 1'b0;
            item_pulse_reg     <= 1'b0;
            collision_prev_reg <= 1'b0;
        end else begin
            state_reg          <= state_next;
            menu_reg           <= menu_next;
            lives_reg          <= lives_next;
            respawn_reg        <= respawn_next;
            lock_reg           <= lock_next;
            game_start_reg     <= game_start_next;
            life_lost_reg      <= life_lost_next;
            item_pulse_reg     <= item_pulse_next;
            collision_prev_reg <= collision;
        end
    end

    assign state      = state_reg;
    assign menu_sel   = menu_reg;
    assign lives      = lives_reg;
    assign game_start = game_start_reg;
    assign life_lost  = life_lost_reg;
    assign item_pulse = item_pulse_reg;

endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Parametrised top-level game flow FSM; successor to the two-option menu controller. Debounces four active-low push keys, runs an N-item wrapping menu, and sequences play, pause, life loss/respawn, instructions and a locked-out game-over screen. It sits between the board keys/collision detector and the renderer/game logic, which consume `state`, `menu_sel`, `lives` and the one-cycle event pulses.

## Interface
- `N_ITEMS`, 3: menu entries, ≥2; item 0 = START, item 1 = HOW TO PLAY, items 2..N_ITEMS-1 = extension items
- `LIVES`, 3: lives per game, ≥1
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles before a key level is accepted, ≥1
- `RESPAWN_CYCLES`, 25000000: length of respawn state, ≥1
- `GO_LOCK_CYCLES`, 50000000: key lockout after entering game over, ≥1
- `clk` in 1: system clock
- `rst` in 1: reset, asynchronous, active-low
- `key_left`, `key_right`, `key_select`, `key_back` in 1 each: raw keys, active-low, asynchronous to clk
- `collision` in 1: level from collision detector, synchronous to clk
- `state` out 3: current state code
- `menu_sel` out SW=max(1,$clog2(N_ITEMS)): highlighted menu item
- `lives` out LW=$clog2(LIVES+1): remaining lives
- `game_start` out 1: one-cycle pulse, new game begins
- `life_lost` out 1: one-cycle pulse, a life was consumed
- `item_pulse` out 1: one-cycle pulse, extension item selected (`menu_sel` identifies it)

## Operation
- State codes: START 0, PLAYING 1, INSTRUCTIONS 2, GAME_OVER 3, PAUSED 4, RESPAWN 5; codes 6–7 unreachable, recover to START next cycle.
- Reset values: state START, menu_sel 0, lives LIVES, all pulses 0, debounced key levels 1 (released), all counters 0.
- Key path per key: 2-flop synchroniser → debouncer; debounced level follows synchronised level only after DEBOUNCE_CYCLES consecutive cycles of disagreement; any return to agreement clears the counter. Press event = debounced 1→0, one cycle. Release produces nothing.
- Collision event = `collision` high this cycle and low the previous cycle (registered edge).
- START: right increments menu_sel, wrapping N_ITEMS-1→0; left decrements, wrapping 0→N_ITEMS-1; left+right same cycle: no change. Select: item 0 → PLAYING, lives←LIVES, game_start pulse; item 1 → INSTRUCTIONS; item ≥2 → item_pulse, stay in START. Select with left/right in same cycle: select acts on current menu_sel, move discarded. Back ignored.
- INSTRUCTIONS: back → START (menu_sel unchanged); other keys ignored.
- PLAYING: collision event → life_lost, lives−1; if lives was 1 → GAME_OVER, else → RESPAWN. Back (no collision) → PAUSED. Collision and back same cycle: collision wins.
- PAUSED: back or select → PLAYING; collision ignored.
- RESPAWN: counter runs RESPAWN_CYCLES cycles, then → PLAYING; keys and collisions ignored.
- GAME_OVER: keys ignored for GO_LOCK_CYCLES cycles after entry; afterwards select or back → START, menu_sel←0.
- lives never underflows; it is only reloaded on a new game.

## Timing
- Raw key falling edge stable thereafter → press event exactly DEBOUNCE_CYCLES+2 cycles later (2 sync + counter); state/menu_sel update on the following edge.
- Collision rising on cycle n → state, lives, life_lost registered at edge n+1.
- All pulses registered, high exactly one cycle, coincident with the state change that causes them.
- RESPAWN occupies exactly RESPAWN_CYCLES cycles; GAME_OVER accepts a key on cycle GO_LOCK_CYCLES after entry at the earliest.
- rst assertion mid-operation: all registers to reset values immediately; pulses drop asynchronously.

## Structure
- Shared package: state code constants (START..RESPAWN) for renderer/game logic use.
- One sub-module `key_debounce` (params DEBOUNCE_CYCLES; ports clk, rst, key_n, level, press), instanced four times; FSM, counters and collision edge in top.

## Test plan
- Reset then idle: state 0, menu_sel 0, lives 3, no pulses; 2-cycle glitch on key_right with DEBOUNCE_CYCLES=4 → no menu change.
- N_ITEMS=3: right ×3 → menu_sel 1,2,0; left at 0 → 2; select at 2 → item_pulse one cycle, state stays 0; left+right together → no change.
- Select at 0 → state 1, game_start one cycle, lives 3; back → state 4; collision during PAUSED → lives stays 3; select → state 1.
- Three collision edges with RESPAWN_CYCLES=8: lives 2 (state 5 for 8 cycles, then 1), 1, then 0 and state 3; held collision level counts once.
- GAME_OVER with GO_LOCK_CYCLES=16: select during lockout ignored; select after → state 0, menu_sel 0; collision+back same cycle in PLAYING → life lost, not paused.
- rst asserted mid-RESPAWN and mid-debounce → immediate reset values; release → clean START behaviour.
